// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-cycle, four-lane, doubleword-addressed data RAM.
// Handles one request at a time and performs read-modify-write for stores that only partly cover a lane.
module lsu_mem_ctrl #(
  parameter int DW = 64,
  parameter int AW = 27
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [63:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          ram1_en,
  output logic          ram2_en,
  output logic          ram3_en,
  output logic          ram4_en,
  output logic [AW-1:0] mem_addr,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, MERGE, RESP} state_t;

  state_t        state, state_nx;
  logic          r_we, r_uns, r_rmw;
  logic [1:0]    r_size;
  logic [2:0]    r_off;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_bmask;
  logic [3:0]    r_lanes;
  logic [DW-1:0] r_wsh, merge_q;

  // Request decode: byte set, lane set and whether the byte set exactly fills its lanes.
  logic [2:0]    req_off, align_mask;
  logic          req_mis, req_rmw;
  logic [7:0]    size_bytes, req_bmask, span_mask;
  logic [3:0]    req_lanes;
  logic [DW-1:0] req_bmask64, req_wsh, r_bmask64, ld_sh, ld_ext, merged;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[63:AW+3];
  assign req_off        = req_addr[2:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    align_mask = 3'b000;
    size_bytes = 8'h01;
    case (req_size)
      2'd0: begin align_mask = 3'b000; size_bytes = 8'h01; end
      2'd1: begin align_mask = 3'b001; size_bytes = 8'h03; end
      2'd2: begin align_mask = 3'b011; size_bytes = 8'h0F; end
      default: begin align_mask = 3'b111; size_bytes = 8'hFF; end
    endcase
    req_mis   = (req_off & align_mask) != 3'b000;
    req_bmask = size_bytes << req_off;
    req_lanes = {|req_bmask[7:4], |req_bmask[3:2], req_bmask[1], req_bmask[0]};
    span_mask = {{4{req_lanes[3]}}, {2{req_lanes[2]}}, req_lanes[1], req_lanes[0]};
    req_rmw   = span_mask != req_bmask;
    for (int i = 0; i < 8; i++) begin
      req_bmask64[8*i +: 8] = {8{req_bmask[i]}};
      r_bmask64[8*i +: 8]   = {8{r_bmask[i]}};
    end
    req_wsh = (req_wdata << {req_off, 3'b000}) & req_bmask64;
    merged  = (mem_rdata & ~r_bmask64) | r_wsh;
  end

  // Load alignment and extension from the raw RAM word.
  always_comb begin
    ld_sh  = mem_rdata >> {r_off, 3'b000};
    ld_ext = ld_sh;
    case (r_size)
      2'd0: ld_ext = r_uns ? {56'd0, ld_sh[7:0]}  : {{56{ld_sh[7]}},  ld_sh[7:0]};
      2'd1: ld_ext = r_uns ? {48'd0, ld_sh[15:0]} : {{48{ld_sh[15]}}, ld_sh[15:0]};
      2'd2: ld_ext = r_uns ? {32'd0, ld_sh[31:0]} : {{32{ld_sh[31]}}, ld_sh[31:0]};
      default: ld_ext = ld_sh;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_wr_en  = 1'b0;
    {ram4_en, ram3_en, ram2_en, ram1_en} = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_mis ? RESP : ACC;
      end
      ACC: begin
        // An RMW read fetches the word without enabling any lane.
        if (!(r_we && r_rmw)) {ram4_en, ram3_en, ram2_en, ram1_en} = r_lanes;
        mem_wr_en = r_we && !r_rmw;
        state_nx  = (r_we && r_rmw) ? MERGE : RESP;
      end
      MERGE: begin
        {ram4_en, ram3_en, ram2_en, ram1_en} = r_lanes;
        mem_wr_en = 1'b1;
        state_nx  = RESP;
      end
      default: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nx = IDLE;
      end
    endcase
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = mem_wr_en ? ((state == MERGE) ? merge_q : r_wsh) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we       <= 1'b0;
      r_uns      <= 1'b0;
      r_rmw      <= 1'b0;
      r_size     <= 2'd0;
      r_off      <= 3'd0;
      r_addr     <= '0;
      r_bmask    <= 8'h00;
      r_lanes    <= 4'h0;
      r_wsh      <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          r_we       <= req_we;
          r_uns      <= req_unsigned;
          r_rmw      <= req_rmw;
          r_size     <= req_size;
          r_off      <= req_off;
          r_addr     <= req_addr[AW+2:3];
          r_bmask    <= req_bmask;
          r_lanes    <= req_lanes;
          r_wsh      <= req_wsh;
          resp_rdata <= '0;
          resp_err   <= req_mis;
        end
        ACC: begin
          if (!r_we)      resp_rdata <= ld_ext;
          else if (r_rmw) merge_q    <= merged;
        end
        RESP: if (resp_ready) resp_err <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store controller directly upstream of the single-cycle data RAM (four lanes: lane1 = byte0, lane2 = byte1, lane3 = bytes2-3, lane4 = bytes4-7, doubleword-addressed).
- Accepts one core memory request at a time via valid/ready and generates the lane enables, doubleword address, write strobe and write data.
- Returns aligned, sign/zero-extended load data.
- Stores that only partly cover a lane are performed as read-modify-write.

Parameters:
- DW, 64, RAM data width (fixed at 64; lane map depends on it)
- AW, 27, RAM doubleword address width

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  zero-extend load (ignored for double)
- req_addr  in  64  byte address
- req_wdata  in  64  store data, right-aligned
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumed
- resp_rdata  out  64  extended load data (0 for stores)
- resp_err  out  1  misaligned request
- ram1_en, ram2_en, ram3_en, ram4_en  out  1 each  lane enables to RAM
- mem_addr  out  AW  doubleword address = latched req_addr[AW+2:3]
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  64  RAM write data, byte-positioned
- mem_rdata  in  64  RAM read data, valid before the posedge that ends the cycle in which mem_addr is driven

Behaviour:
- Reset (async, rst_n low): state IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; all ram*_en=0; mem_wr_en=0; mem_addr=0; mem_wdata=0. Reset mid-operation aborts with no write and no response.
- States: IDLE, ACC, MERGE, RESP. req_ready = (state==IDLE).
- Accept on posedge with req_valid&req_ready; latch all req_* fields. Upper address bits above AW+2 are ignored.
- Misaligned (addr[2:0] not a multiple of 1<<size): IDLE -> RESP, resp_err=1, no RAM access.
- Byte set B = bytes addr[2:0] .. addr[2:0]+(1<<size)-1. Lane set L = every lane touching B.
- Lane enables are asserted only in ACC and MERGE; they equal L for loads and direct stores, and are 0 for an RMW read.
- Load: in ACC, drive mem_addr and enables; at end of ACC, capture mem_rdata >> (8*addr[2:0]), truncate to size, sign- or zero-extend -> resp_rdata; then RESP. Accept edge to resp_valid = 2 edges.
- Direct store (B exactly equals the byte span of L): in ACC, mem_wr_en=1, mem_wdata = req_wdata << (8*addr[2:0]); then RESP.
- RMW store (B is a strict subset of the span of L):
  - In ACC, read only (mem_wr_en=0); capture mem_rdata into the merge buffer.
  - In MERGE, mem_wr_en=1, enables=L, mem_wdata = buffer with bytes B replaced by the shifted store data.
  - Then RESP. Accept edge to resp_valid = 3 edges.
- RMW cases: byte at offset 2-7; half at offset 4 or 6.
- RESP: resp_valid held with stable data until resp_valid&resp_ready; on that edge go to IDLE and clear resp_valid/resp_err. A new request cannot be accepted in that same cycle.
- mem_wr_en is never high outside ACC/MERGE; it is high for exactly one cycle per store.

Test Plan:
- Reset mid-RMW: assert rst_n=0 during MERGE -> all outputs at reset values, RAM contents unchanged, no resp_valid.
- Store double 0x1122334455667788 at 0x100, then load double at 0x100 -> all four enables high, mem_addr=0x20, resp_rdata=0x1122334455667788, resp_valid 2 edges after accept.
- Load byte signed at 0x107 after the above -> resp_rdata=0x0000000000000011. Store byte 0x80 at 0x101 (direct, ram2 only), then load byte signed at 0x101 -> 0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
- Store byte 0xAB at 0x102 (RMW) -> ACC read with enables=0, then MERGE write with ram3_en only and mem_wdata[31:16]=0x55AB. A following load half at 0x102 -> 0x55AB.
- Store half 0xBEEF at 0x106 (RMW on lane4) -> reload double = 0xBEEF334455AB8088.
- Load word at 0x102 -> resp_err=1, resp_valid 1 edge after accept, no enables, no mem_wr_en. Hold resp_ready=0 for 3 cycles -> response stable and req_ready=0 throughout.
